riscv_multicycle_controller: RTL and testbench
==============================================

Name: riscv_multicycle_controller

Overview:
Multi-cycle successor to the single-cycle main controller. One shared memory port and one ALU are time-multiplexed across fetch, decode, execute, memory and writeback states. Memory is reached through either a ready handshake or a parametrised fixed-latency wait. The block sits beside the multi-cycle datapath under the core top and also provides a retired-instruction counter and a sticky illegal-opcode trap.

Parameters:
MEM_HANDSHAKE, 1, 1 = memory states wait on mem_ready; 0 = an internal counter waits MEM_LATENCY cycles and mem_ready is ignored
MEM_LATENCY, 2, cycles per memory access when MEM_HANDSHAKE=0; legal range >=1
ENABLE_JAL, 1, 1 = decode JAL (1101111); 0 = JAL traps as illegal
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
opcode  in  7  instruction[6:0] from the datapath instruction register
mem_ready  in  1  memory access completes this cycle (handshake mode only)
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if datapath zero flag is set (branch)
ir_write  out  1  instruction register load
i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
mem_to_reg  out  2  writeback select: 00 = ALUOut, 01 = MDR, 10 = PC (PC+4 after fetch)
reg_write  out  1  register file write
alu_src_a  out  2  ALU A select: 00 = PC, 01 = rs1, 10 = old PC
alu_src_b  out  2  ALU B select: 00 = rs2, 01 = const 4, 10 = immediate
alu_op  out  2  00 = add, 01 = sub/branch, 10 = R-funct, 11 = I-funct
pc_source  out  2  PC next select: 00 = ALU result, 01 = ALUOut
instr_done  out  1  one-cycle pulse on the last cycle of each instruction
instret  out  CNT_W  retired-instruction count
illegal  out  1  sticky trap flag
state_o  out  4  current state encoding, for debug

Behaviour:
- Reset: state = IDLE, instret = 0, illegal = 0, wait counter = 0. All outputs are 0 in IDLE. IDLE -> FETCH unconditionally on the first edge after rst deasserts.
- Outputs are Moore, decoded from state. Exception: ir_write, pc_write in FETCH and the memory-done transitions are qualified by mem_ok.
- mem_ok: in handshake mode, mem_ok = mem_ready. In fixed mode, mem_ok = (wcnt == MEM_LATENCY-1). wcnt clears on every entry to FETCH, MEM_RD or MEM_WR and increments while in those states.
- Per-state outputs and next state (outputs not listed are 0):
  - FETCH: mem_read=1, i_or_d=0, a=00, b=01, alu_op=00, pc_source=00. Holds until mem_ok; in that cycle ir_write=1, pc_write=1 -> DECODE.
  - DECODE: a=10, b=10, alu_op=00 (branch target into ALUOut). Dispatch on opcode:
    - 0110011 -> EXEC_R
    - 0010011 -> EXEC_I
    - 0000011 or 0100011 -> MEM_ADDR
    - 1100011 -> BRANCH
    - 1101111 -> JAL (when ENABLE_JAL=1)
    - anything else -> TRAP
  - EXEC_R: a=01, b=00, alu_op=10 -> WB_ALU.
  - EXEC_I: a=01, b=10, alu_op=11 -> WB_ALU.
  - WB_ALU: reg_write=1, mem_to_reg=00 -> FETCH, instr_done.
  - MEM_ADDR: a=01, b=10, alu_op=00. Load -> MEM_RD; store -> MEM_WR. Opcode is taken from the IR, stable since FETCH.
  - MEM_RD: mem_read=1, i_or_d=1. Holds until mem_ok -> WB_MEM.
  - WB_MEM: reg_write=1, mem_to_reg=01 -> FETCH, instr_done.
  - MEM_WR: mem_write=1, i_or_d=1. Holds until mem_ok -> FETCH, instr_done.
  - BRANCH: a=01, b=00, alu_op=01, pc_write_cond=1, pc_source=01 -> FETCH, instr_done.
  - JAL: pc_write=1, pc_source=01, reg_write=1, mem_to_reg=10 -> FETCH, instr_done.
  - TRAP: illegal=1, all other outputs 0. Terminal until rst; no instr_done.
- Memory request handling: mem_read/mem_write stay high and i_or_d stays stable for every waiting cycle. mem_ready in non-memory states is ignored.
- instret increments on every instr_done, wrapping modulo 2^CNT_W. A branch counts as retired whether or not it is taken.
- Cycle counts (fixed mode, MEM_LATENCY=L): R/I = L+3, load = 2L+3, store = 2L+2, branch = L+2, JAL = L+2.
- rst asserted mid-instruction: immediate return to IDLE and all outputs drop in the same cycle. Counts and the trap flag clear.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - state enum (IDLE, FETCH, DECODE, EXEC_R, EXEC_I, WB_ALU, MEM_ADDR, MEM_RD, WB_MEM, MEM_WR, BRANCH, JAL, TRAP; 4-bit encoding)
  - opcode constants
  - mux-select and alu_op localparams, shared with the datapath
- Sub-module mem_wait_timer (parameter MEM_LATENCY): inputs clk, rst, clear, active; output done. Used only when MEM_HANDSHAKE=0, via a generate.

Test Plan:
- Reset/IDLE: assert rst mid-FETCH -> all outputs 0 at once, instret=0; release -> one IDLE cycle, then FETCH with mem_read=1.
- Handshake R-type: opcode=0110011, mem_ready low 3 cycles then high -> ir_write and pc_write pulse once; WB_ALU reg_write=1; instr_done once; instret=1.
- Fixed latency, MEM_HANDSHAKE=0, MEM_LATENCY=3: load -> 9 cycles FETCH-to-FETCH, mem_read high 3 cycles in MEM_RD, WB_MEM mem_to_reg=01; store -> 8 cycles, mem_write high 3 cycles.
- Branch then JAL: BRANCH asserts pc_write_cond=1, alu_op=01; JAL asserts pc_write=1, reg_write=1, mem_to_reg=10; instret advances by 2.
- Illegal: opcode=1111111 (or JAL with ENABLE_JAL=0) -> TRAP, illegal=1 held for 20 cycles, no memory requests, instret frozen; rst clears it.
- Counter wrap: CNT_W=4, 17 R-type instructions -> instret=1.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared state encoding, opcode constants and datapath mux selects for the
// multi-cycle RISC-V controller and its datapath.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_EXEC_R   = 4'd3,
    ST_EXEC_I   = 4'd4,
    ST_WB_ALU   = 4'd5,
    ST_MEM_ADDR = 4'd6,
    ST_MEM_RD   = 4'd7,
    ST_WB_MEM   = 4'd8,
    ST_MEM_WR   = 4'd9,
    ST_BRANCH   = 4'd10,
    ST_JAL      = 4'd11,
    ST_TRAP     = 4'd12
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_RS1   = 2'b01;
  localparam logic [1:0] SRC_A_OLDPC = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_RFUNCT = 2'b10;
  localparam logic [1:0] ALU_IFUNCT = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

endpackage

// File: rtl/riscv_multicycle_controller_timer.sv
// Fixed-latency memory wait: done is high on the last cycle of an access that
// has been active for MEM_LATENCY cycles since the last clear.
module mem_wait_timer #(
  parameter int MEM_LATENCY = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic active,
  output logic done
);

  localparam int W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  logic [W-1:0] cnt_q;

  assign done = (cnt_q == W'(MEM_LATENCY - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (active && !done) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/riscv_multicycle_controller.sv
// Multi-cycle main controller: Moore control decode per state, shared memory
// port with handshake or fixed-latency wait, retired counter and sticky trap.
module riscv_multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int MEM_HANDSHAKE = 1,
  parameter int MEM_LATENCY   = 2,
  parameter int ENABLE_JAL    = 1,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             ir_write,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic [1:0]       mem_to_reg,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             instr_done,
  output logic [CNT_W-1:0] instret,
  output logic             illegal,
  output logic [3:0]       state_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instret_q;
  logic             illegal_q;
  logic             mem_state;
  logic             mem_ok;

  assign mem_state = (state_q == ST_FETCH) || (state_q == ST_MEM_RD) || (state_q == ST_MEM_WR);

  generate
    if (MEM_HANDSHAKE != 0) begin : g_handshake
      assign mem_ok = mem_ready;
    end else begin : g_fixed
      logic unused_mem_ready;
      assign unused_mem_ready = mem_ready;
      // Clearing whenever idle or finishing guarantees a zero count on every entry.
      mem_wait_timer #(.MEM_LATENCY(MEM_LATENCY)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (!mem_state || mem_ok),
        .active (mem_state),
        .done   (mem_ok)
      );
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     state_d = ST_FETCH;
      ST_FETCH:    if (mem_ok) state_d = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_R:               state_d = ST_EXEC_R;
          OP_I:               state_d = ST_EXEC_I;
          OP_LOAD, OP_STORE:  state_d = ST_MEM_ADDR;
          OP_BRANCH:          state_d = ST_BRANCH;
          OP_JAL:             state_d = (ENABLE_JAL != 0) ? ST_JAL : ST_TRAP;
          default:            state_d = ST_TRAP;
        endcase
      end
      ST_EXEC_R, ST_EXEC_I: state_d = ST_WB_ALU;
      ST_MEM_ADDR: state_d = (opcode == OP_LOAD) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD:   if (mem_ok) state_d = ST_WB_MEM;
      ST_MEM_WR:   if (mem_ok) state_d = ST_FETCH;
      ST_WB_ALU, ST_WB_MEM, ST_BRANCH, ST_JAL: state_d = ST_FETCH;
      ST_TRAP:     state_d = ST_TRAP;
      default:     state_d = ST_IDLE;
    endcase
  end

  assign instr_done = (state_q == ST_WB_ALU) || (state_q == ST_WB_MEM) ||
                      (state_q == ST_BRANCH) || (state_q == ST_JAL) ||
                      ((state_q == ST_MEM_WR) && mem_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      instret_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (instr_done) instret_q <= instret_q + CNT_W'(1);
      if (state_d == ST_TRAP) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = WB_ALUOUT;
    reg_write     = 1'b0;
    alu_src_a     = SRC_A_PC;
    alu_src_b     = SRC_B_RS2;
    alu_op        = ALU_ADD;
    pc_source     = PC_SRC_ALU;
    case (state_q)
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRC_B_FOUR;
        ir_write  = mem_ok;
        pc_write  = mem_ok;
      end
      ST_DECODE: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
      end
      ST_EXEC_R: begin
        alu_src_a = SRC_A_RS1;
        alu_op    = ALU_RFUNCT;
      end
      ST_EXEC_I: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        alu_op    = ALU_IFUNCT;
      end
      ST_WB_ALU: reg_write = 1'b1;
      ST_MEM_ADDR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
      end
      ST_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      ST_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = WB_MDR;
      end
      ST_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a     = SRC_A_RS1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PC_SRC_ALUOUT;
      end
      ST_JAL: begin
        pc_write   = 1'b1;
        pc_source  = PC_SRC_ALUOUT;
        reg_write  = 1'b1;
        mem_to_reg = WB_PC;
      end
      default: ;
    endcase
  end

  assign instret = instret_q;
  assign illegal = illegal_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_riscv_multicycle_controller.sv
// Scoreboard bench: each issued instruction pushes its expected per-cycle state
// trajectory; every cycle pops one entry and compares the controller outputs.
module tb_riscv_multicycle_controller;

  localparam int L = 3;
  localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_EXEC_R = 4'd3,
                         S_EXEC_I = 4'd4, S_WB_ALU = 4'd5, S_MEM_ADDR = 4'd6, S_MEM_RD = 4'd7,
                         S_WB_MEM = 4'd8, S_MEM_WR = 4'd9, S_BRANCH = 4'd10, S_JAL = 4'd11,
                         S_TRAP = 4'd12;
  localparam logic [6:0] C_R = 7'b0110011, C_I = 7'b0010011, C_LD = 7'b0000011,
                         C_ST = 7'b0100011, C_BR = 7'b1100011, C_JAL = 7'b1101111,
                         C_BAD = 7'b1111111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_hs, rst_fx, mem_ready, sel;
  logic [6:0] opcode;

  logic pw_hs, pwc_hs, irw_hs, iod_hs, mr_hs, mw_hs, rw_hs, done_hs, ill_hs;
  logic [1:0] m2r_hs, a_hs, b_hs, op_hs, pcs_hs;
  logic [3:0] st_hs, cnt_hs;
  logic pw_fx, pwc_fx, irw_fx, iod_fx, mr_fx, mw_fx, rw_fx, done_fx, ill_fx;
  logic [1:0] m2r_fx, a_fx, b_fx, op_fx, pcs_fx;
  logic [3:0] st_fx;
  logic [31:0] cnt_fx;

  riscv_multicycle_controller #(.MEM_HANDSHAKE(1), .MEM_LATENCY(2), .ENABLE_JAL(1), .CNT_W(4)) dut_hs (
    .clk(clk), .rst(rst_hs), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pw_hs), .pc_write_cond(pwc_hs), .ir_write(irw_hs), .i_or_d(iod_hs),
    .mem_read(mr_hs), .mem_write(mw_hs), .mem_to_reg(m2r_hs), .reg_write(rw_hs),
    .alu_src_a(a_hs), .alu_src_b(b_hs), .alu_op(op_hs), .pc_source(pcs_hs),
    .instr_done(done_hs), .instret(cnt_hs), .illegal(ill_hs), .state_o(st_hs));

  riscv_multicycle_controller #(.MEM_HANDSHAKE(0), .MEM_LATENCY(L), .ENABLE_JAL(0), .CNT_W(32)) dut_fx (
    .clk(clk), .rst(rst_fx), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pw_fx), .pc_write_cond(pwc_fx), .ir_write(irw_fx), .i_or_d(iod_fx),
    .mem_read(mr_fx), .mem_write(mw_fx), .mem_to_reg(m2r_fx), .reg_write(rw_fx),
    .alu_src_a(a_fx), .alu_src_b(b_fx), .alu_op(op_fx), .pc_source(pcs_fx),
    .instr_done(done_fx), .instret(cnt_fx), .illegal(ill_fx), .state_o(st_fx));

  logic [16:0] obs_ctrl;
  logic [31:0] obs_cnt;
  logic [3:0]  obs_st;
  logic        obs_done, obs_ill;
  always_comb begin
    obs_ctrl = sel ? {pw_fx, pwc_fx, irw_fx, iod_fx, mr_fx, mw_fx, m2r_fx, rw_fx, a_fx, b_fx, op_fx, pcs_fx}
                   : {pw_hs, pwc_hs, irw_hs, iod_hs, mr_hs, mw_hs, m2r_hs, rw_hs, a_hs, b_hs, op_hs, pcs_hs};
    obs_cnt  = sel ? cnt_fx : {28'd0, cnt_hs};
    obs_st   = sel ? st_fx : st_hs;
    obs_done = sel ? done_fx : done_hs;
    obs_ill  = sel ? ill_fx : ill_hs;
  end

  typedef struct {
    logic [3:0] st;
    logic       ok;
    logic       dn;
  } exp_t;
  exp_t sb_q[$];

  int n_checks = 0, n_errors = 0;
  int len_cnt = 0, last_len = 0;
  logic [31:0] exp_cnt = 0;
  logic [6:0]  cur_op;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected control word, field order {pw,pwc,irw,iod,mr,mw,m2r,rw,a,b,op,pcs}
  function automatic logic [16:0] exp_ctrl(input logic [3:0] st, input logic ok);
    logic pw, pwc, irw, iod, mr, mw, rw;
    logic [1:0] m2r, a, b, op, pcs;
    {pw, pwc, irw, iod, mr, mw, rw} = 7'b0;
    {m2r, a, b, op, pcs} = 10'b0;
    case (st)
      S_FETCH:    begin mr = 1; b = 2'b01; irw = ok; pw = ok; end
      S_DECODE:   begin a = 2'b10; b = 2'b10; end
      S_EXEC_R:   begin a = 2'b01; op = 2'b10; end
      S_EXEC_I:   begin a = 2'b01; b = 2'b10; op = 2'b11; end
      S_WB_ALU:   rw = 1;
      S_MEM_ADDR: begin a = 2'b01; b = 2'b10; end
      S_MEM_RD:   begin mr = 1; iod = 1; end
      S_WB_MEM:   begin rw = 1; m2r = 2'b01; end
      S_MEM_WR:   begin mw = 1; iod = 1; end
      S_BRANCH:   begin a = 2'b01; op = 2'b01; pwc = 1; pcs = 2'b01; end
      S_JAL:      begin pw = 1; pcs = 2'b01; rw = 1; m2r = 2'b10; end
      default: ;
    endcase
    return {pw, pwc, irw, iod, mr, mw, m2r, rw, a, b, op, pcs};
  endfunction

  task automatic push_run(input logic [3:0] st, input int n, input logic dn_last);
    for (int i = 0; i < n; i++) sb_q.push_back('{st, (i == n - 1), (dn_last && (i == n - 1))});
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] mask;
    mask = sel ? 32'hFFFF_FFFF : 32'h0000_000F;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      opcode = cur_op;
      if (!sel && (e.st == S_FETCH || e.st == S_MEM_RD || e.st == S_MEM_WR)) mem_ready = e.ok;
      else mem_ready = 1'($urandom_range(0, 1));
      #1;
      check_eq($sformatf("state op=%b", cur_op), obs_st, e.st);
      check_eq($sformatf("ctrl st=%0d", e.st), obs_ctrl, exp_ctrl(e.st, e.ok));
      check_eq($sformatf("done st=%0d", e.st), obs_done, e.dn);
      check_eq($sformatf("illegal st=%0d", e.st), obs_ill, (e.st == S_TRAP));
      check_eq($sformatf("instret st=%0d", e.st), obs_cnt, exp_cnt);
      len_cnt++;
      if (obs_done) last_len = len_cnt;
      if (e.dn) exp_cnt = (exp_cnt + 1) & mask;
      @(negedge clk);
    end
  endtask

  task automatic issue(input logic [6:0] op, input int wt);
    int n;
    n = sel ? L : wt + 1;
    cur_op = op;
    len_cnt = 0;
    push_run(S_FETCH, n, 0);
    push_run(S_DECODE, 1, 0);
    case (op)
      C_R:  begin push_run(S_EXEC_R, 1, 0); push_run(S_WB_ALU, 1, 1); end
      C_I:  begin push_run(S_EXEC_I, 1, 0); push_run(S_WB_ALU, 1, 1); end
      C_LD: begin push_run(S_MEM_ADDR, 1, 0); push_run(S_MEM_RD, n, 0); push_run(S_WB_MEM, 1, 1); end
      C_ST: begin push_run(S_MEM_ADDR, 1, 0); push_run(S_MEM_WR, n, 1); end
      C_BR: push_run(S_BRANCH, 1, 1);
      C_JAL: if (!sel) push_run(S_JAL, 1, 1); else push_run(S_TRAP, 20, 0);
      default: push_run(S_TRAP, 20, 0);
    endcase
    drain();
  endtask

  // Called at a negedge: asserts reset between edges, checks immediate drop,
  // releases it and leaves the bench at the first FETCH negedge.
  task automatic async_reset();
    mem_ready = 1'b0;
    #3;
    if (sel) rst_fx = 1'b1; else rst_hs = 1'b1;
    #1;
    check_eq("rst_ctrl", obs_ctrl, 17'd0);
    check_eq("rst_state", obs_st, S_IDLE);
    check_eq("rst_instret", obs_cnt, 32'd0);
    check_eq("rst_illegal", obs_ill, 1'b0);
    check_eq("rst_done", obs_done, 1'b0);
    @(negedge clk);
    #1;
    if (sel) rst_fx = 1'b0; else rst_hs = 1'b0;
    check_eq("idle_after_rst", obs_st, S_IDLE);
    check_eq("idle_ctrl", obs_ctrl, 17'd0);
    exp_cnt = 0;
    @(negedge clk);
  endtask

  initial begin
    rst_hs = 1'b1; rst_fx = 1'b1; mem_ready = 1'b0; sel = 1'b0;
    opcode = C_R; cur_op = C_R;
    @(negedge clk);
    async_reset();

    issue(C_R, 3);
    check_eq("instret_after_r", obs_cnt, 32'd1);
    issue(C_I, 0);
    issue(C_LD, 2);
    issue(C_ST, 1);
    issue(C_BR, 0);
    issue(C_JAL, 1);
    check_eq("instret_after_6", obs_cnt, 32'd6);

    #1 check_eq("mid_fetch_state", obs_st, S_FETCH);
    #0 async_reset();
    for (int i = 0; i < 17; i++) issue(C_R, i % 3);
    check_eq("instret_wrap", obs_cnt, 32'd1);

    issue(C_BAD, 0);
    check_eq("trap_held", obs_ill, 1'b1);
    async_reset();

    sel = 1'b1;
    rst_hs = 1'b1;
    async_reset();
    issue(C_LD, 0);
    check_eq("fx_load_cycles", last_len, 9);
    issue(C_ST, 0);
    check_eq("fx_store_cycles", last_len, 8);
    issue(C_R, 0);
    check_eq("fx_r_cycles", last_len, 6);
    issue(C_BR, 0);
    check_eq("fx_branch_cycles", last_len, 5);
    check_eq("fx_instret", obs_cnt, 32'd4);
    issue(C_JAL, 0);
    check_eq("fx_jal_trap", obs_ill, 1'b1);
    async_reset();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
